// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the req/gnt memory model: response record and byte-enable merge.
package mem_model_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_BE_W       = MEM_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [MEM_DATA_WIDTH-1:0] rdata;
    } mem_resp_t;

    function automatic logic [MEM_DATA_WIDTH-1:0] be_merge(
        input logic [MEM_DATA_WIDTH-1:0] old_word,
        input logic [MEM_DATA_WIDTH-1:0] wdata,
        input logic [MEM_BE_W-1:0]       be
    );
        logic [MEM_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MEM_BE_W; i++) begin
            if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/req_gnt_mem_model_port_ctrl.sv
// One request port: grant wait counter, address decode and the in-order response pipeline.
module req_gnt_port_ctrl
    import mem_model_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    GNT_WAIT   = 0,
    parameter int                    RVALID_LAT = 1,
    parameter int                    OFF_W      = 2,
    parameter int                    IDX_W      = 10
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      req,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      we,
    input  logic [MEM_DATA_WIDTH-1:0] rdata_word,
    output logic                      gnt,
    output logic                      accept,
    output logic [IDX_W-1:0]          idx,
    output logic                      bad,
    output logic                      rvalid,
    output logic                      err,
    output logic [MEM_DATA_WIDTH-1:0] rdata
);

    localparam int CNT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

    logic [CNT_W-1:0]      cnt_reg;
    logic                  below_base;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] word_off;
    logic                  s0_valid_reg;
    logic                  s0_err_reg;
    logic                  s0_read_reg;
    mem_resp_t             resp0;
    mem_resp_t             resp_out;

    // Borrow out of the subtraction flags addresses below the window.
    assign {below_base, off} = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign word_off = off >> OFF_W;
    assign idx      = word_off[IDX_W-1:0];
    assign bad      = below_base | (word_off >= ADDR_WIDTH'(DEPTH)) | ((addr & OFF_MASK) != '0);

    assign gnt    = req & ~srst & (cnt_reg == CNT_W'(GNT_WAIT));
    assign accept = gnt;

    always_ff @(posedge clk) begin
        if (srst || !req || accept) cnt_reg <= '0;
        else                        cnt_reg <= cnt_reg + 1'b1;
    end

    // First stage records the access kind; read data arrives from the array register alongside it.
    always_ff @(posedge clk) begin
        if (srst) begin
            s0_valid_reg <= 1'b0;
            s0_err_reg   <= 1'b0;
            s0_read_reg  <= 1'b0;
        end else begin
            s0_valid_reg <= accept;
            s0_err_reg   <= accept & bad;
            s0_read_reg  <= accept & ~we & ~bad;
        end
    end

    always_comb begin
        resp0       = '0;
        resp0.valid = s0_valid_reg;
        resp0.err   = s0_err_reg;
        resp0.rdata = s0_read_reg ? rdata_word : '0;
    end

    if (RVALID_LAT == 1) begin : g_lat1
        assign resp_out = resp0;
    end else begin : g_pipe
        mem_resp_t pipe_reg [RVALID_LAT-1];
        always_ff @(posedge clk) begin
            if (srst) begin
                for (int i = 0; i < RVALID_LAT - 1; i++) pipe_reg[i] <= '0;
            end else begin
                pipe_reg[0] <= resp0;
                for (int i = 1; i < RVALID_LAT - 1; i++) pipe_reg[i] <= pipe_reg[i-1];
            end
        end
        assign resp_out = pipe_reg[RVALID_LAT-2];
    end

    assign rvalid = resp_out.valid;
    assign err    = resp_out.err;
    assign rdata  = resp_out.rdata;

endmodule

// File: rtl/req_gnt_mem_model.sv
// Dual-port memory slave (instruction port 0, data port 1) with req/gnt/rvalid handshake.
module req_gnt_mem_model
    import mem_model_pkg::*;
#(
    parameter int                    DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    GNT_WAIT   = 0,
    parameter int                    RVALID_LAT = 1,
    parameter string                 INIT_FILE  = ""
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    port_req_i    [2],
    output logic                    port_gnt_o    [2],
    input  logic [ADDR_WIDTH-1:0]   port_addr_i   [2],
    input  logic                    port_we_i     [2],
    input  logic [DATA_WIDTH/8-1:0] port_be_i     [2],
    input  logic [DATA_WIDTH-1:0]   port_wdata_i  [2],
    output logic                    port_rvalid_o [2],
    output logic [DATA_WIDTH-1:0]   port_rdata_o  [2],
    output logic                    port_err_o    [2]
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_reg [2];
    logic [IDX_W-1:0]      idx [2];
    logic [1:0]            accept;
    logic [1:0]            bad;
    logic [1:0]            wr;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        req_gnt_port_ctrl #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH),
            .BASE_ADDR  (BASE_ADDR),
            .GNT_WAIT   (GNT_WAIT),
            .RVALID_LAT (RVALID_LAT),
            .OFF_W      (OFF_W),
            .IDX_W      (IDX_W)
        ) u_port_ctrl (
            .clk        (clk_i),
            .srst       (rst_i),
            .req        (port_req_i[gi]),
            .addr       (port_addr_i[gi]),
            .we         (port_we_i[gi]),
            .rdata_word (rd_word_reg[gi]),
            .gnt        (port_gnt_o[gi]),
            .accept     (accept[gi]),
            .idx        (idx[gi]),
            .bad        (bad[gi]),
            .rvalid     (port_rvalid_o[gi]),
            .err        (port_err_o[gi]),
            .rdata      (port_rdata_o[gi])
        );

        assign wr[gi] = accept[gi] & port_we_i[gi] & ~bad[gi];
    end

    // Reads sample the pre-edge word; a same-word double write merges with port 1 on top.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            if (accept[p] && !port_we_i[p] && !bad[p]) rd_word_reg[p] <= mem[idx[p]];
        end
        if (wr[0] && wr[1] && (idx[0] == idx[1])) begin
            mem[idx[1]] <= be_merge(be_merge(mem[idx[0]], port_wdata_i[0], port_be_i[0]),
                                    port_wdata_i[1], port_be_i[1]);
        end else begin
            if (wr[0]) mem[idx[0]] <= be_merge(mem[idx[0]], port_wdata_i[0], port_be_i[0]);
            if (wr[1]) mem[idx[1]] <= be_merge(mem[idx[1]], port_wdata_i[1], port_be_i[1]);
        end
    end

endmodule

// File: tb/tb_req_gnt_mem_model.sv
// Directed bench: instance 0 (wait 0, lat 1), instance 1 (wait 2, lat 1), instance 2 (wait 0, lat 3).
module tb_req_gnt_mem_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [3][2];
    logic        gnt    [3][2];
    logic [31:0] addr   [3][2];
    logic        we     [3][2];
    logic [3:0]  be     [3][2];
    logic [31:0] wdata  [3][2];
    logic        rvalid [3][2];
    logic [31:0] rdata  [3][2];
    logic        err    [3][2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        req_gnt_mem_model #(
            .GNT_WAIT   ((gi == 1) ? 2 : 0),
            .RVALID_LAT ((gi == 2) ? 3 : 1)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .port_req_i    (req[gi]),
            .port_gnt_o    (gnt[gi]),
            .port_addr_i   (addr[gi]),
            .port_we_i     (we[gi]),
            .port_be_i     (be[gi]),
            .port_wdata_i  (wdata[gi]),
            .port_rvalid_o (rvalid[gi]),
            .port_rdata_o  (rdata[gi]),
            .port_err_o    (err[gi])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] b);
        req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdata[d][p] = dat; be[d][p] = b;
        #1;
    endtask

    task automatic idle(input int d, input int p);
        req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0; be[d][p] = '0;
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) for (int p = 0; p < 2; p++) req[d][p] = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (gnt[d][p] !== 1'b0 || rvalid[d][p] !== 1'b0 || err[d][p] !== 1'b0 || rdata[d][p] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_outputs d%0d p%0d: gnt=%b rvalid=%b err=%b rdata=%h, expected all zero",
                             d, p, gnt[d][p], rvalid[d][p], err[d][p], rdata[d][p]);
                end
            end
        end
        for (int d = 0; d < 3; d++) for (int p = 0; p < 2; p++) idle(d, p);
        $display("reset: outputs held low with req asserted");
    endtask

    task automatic test_basic_read();
        drive(0, 1, 1'b1, 32'h0, 32'h00300293, 4'hF);
        checks++; if (gnt[0][1] !== 1'b1) begin errors++; $display("FAIL basic_wr_gnt got %b exp 1", gnt[0][1]); end
        tick(); idle(0, 1);
        checks++; if (rvalid[0][1] !== 1'b1 || rdata[0][1] !== 32'h0) begin errors++; $display("FAIL basic_wr_resp rvalid=%b rdata=%h exp 1/00000000", rvalid[0][1], rdata[0][1]); end
        drive(0, 0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (gnt[0][0] !== 1'b1) begin errors++; $display("FAIL basic_rd_gnt got %b exp 1", gnt[0][0]); end
        tick(); idle(0, 0);
        checks++; if (rvalid[0][0] !== 1'b1 || err[0][0] !== 1'b0 || rdata[0][0] !== 32'h00300293) begin errors++; $display("FAIL basic_rd_resp rvalid=%b err=%b rdata=%h exp 1/0/00300293", rvalid[0][0], err[0][0], rdata[0][0]); end
        tick();
        checks++; if (rvalid[0][0] !== 1'b0 || rdata[0][0] !== 32'h0) begin errors++; $display("FAIL basic_rd_single_pulse rvalid=%b rdata=%h exp 0/00000000", rvalid[0][0], rdata[0][0]); end
        $display("basic_read: p0 read addr 0 -> %h", 32'h00300293);
    endtask

    task automatic test_gnt_wait();
        drive(1, 1, 1'b1, 32'h4, 32'h12345678, 4'hF);
        checks++; if (gnt[1][1] !== 1'b0) begin errors++; $display("FAIL wait_cycle1 gnt got %b exp 0", gnt[1][1]); end
        tick();
        checks++; if (gnt[1][1] !== 1'b0) begin errors++; $display("FAIL wait_cycle2 gnt got %b exp 0", gnt[1][1]); end
        tick();
        checks++; if (gnt[1][1] !== 1'b1) begin errors++; $display("FAIL wait_cycle3 gnt got %b exp 1", gnt[1][1]); end
        tick(); idle(1, 1);
        checks++; if (rvalid[1][1] !== 1'b1 || rdata[1][1] !== 32'h0) begin errors++; $display("FAIL wait_wr_resp rvalid=%b rdata=%h exp 1/00000000", rvalid[1][1], rdata[1][1]); end
        // Abandoned write attempt: one req cycle then dropped.
        drive(1, 1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        tick(); idle(1, 1);
        checks++; if (rvalid[1][1] !== 1'b0) begin errors++; $display("FAIL drop_no_resp1 rvalid got %b exp 0", rvalid[1][1]); end
        tick();
        checks++; if (rvalid[1][1] !== 1'b0) begin errors++; $display("FAIL drop_no_resp2 rvalid got %b exp 0", rvalid[1][1]); end
        drive(1, 1, 1'b0, 32'h4, 32'h0, 4'h0);
        tick();
        checks++; if (gnt[1][1] !== 1'b0) begin errors++; $display("FAIL drop_restart gnt got %b exp 0", gnt[1][1]); end
        tick();
        checks++; if (gnt[1][1] !== 1'b1) begin errors++; $display("FAIL drop_regrant gnt got %b exp 1", gnt[1][1]); end
        tick(); idle(1, 1);
        checks++; if (rvalid[1][1] !== 1'b1 || rdata[1][1] !== 32'h12345678) begin errors++; $display("FAIL drop_no_write rvalid=%b rdata=%h exp 1/12345678", rvalid[1][1], rdata[1][1]); end
        $display("gnt_wait: grant on 3rd req cycle, dropped attempt ignored");
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 1'b0, 32'h4, 32'h0, 4'h0);
        tick(); tick(); tick();
        checks++; if (gnt[1][0] !== 1'b0 || rvalid[1][0] !== 1'b1 || rdata[1][0] !== 32'h12345678) begin errors++; $display("FAIL b2b_first gnt=%b rvalid=%b rdata=%h exp 0/1/12345678", gnt[1][0], rvalid[1][0], rdata[1][0]); end
        tick();
        checks++; if (gnt[1][0] !== 1'b0 || rvalid[1][0] !== 1'b0) begin errors++; $display("FAIL b2b_rewait gnt=%b rvalid=%b exp 0/0", gnt[1][0], rvalid[1][0]); end
        tick();
        checks++; if (gnt[1][0] !== 1'b1) begin errors++; $display("FAIL b2b_second_gnt got %b exp 1", gnt[1][0]); end
        tick(); idle(1, 0);
        checks++; if (rvalid[1][0] !== 1'b1 || rdata[1][0] !== 32'h12345678) begin errors++; $display("FAIL b2b_second_resp rvalid=%b rdata=%h exp 1/12345678", rvalid[1][0], rdata[1][0]); end
        $display("back_to_back: held req waits full GNT_WAIT again");
    endtask

    task automatic test_byte_enable();
        drive(0, 1, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF);
        tick(); drive(0, 1, 1'b1, 32'h10, 32'h11223344, 4'b0101);
        checks++; if (rvalid[0][1] !== 1'b1 || rdata[0][1] !== 32'h0) begin errors++; $display("FAIL be_wr1_resp rvalid=%b rdata=%h exp 1/00000000", rvalid[0][1], rdata[0][1]); end
        tick(); drive(0, 1, 1'b0, 32'h10, 32'h0, 4'h0);
        checks++; if (rvalid[0][1] !== 1'b1 || rdata[0][1] !== 32'h0) begin errors++; $display("FAIL be_wr2_resp rvalid=%b rdata=%h exp 1/00000000", rvalid[0][1], rdata[0][1]); end
        tick(); idle(0, 1);
        checks++; if (rvalid[0][1] !== 1'b1 || rdata[0][1] !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge_read rvalid=%b rdata=%h exp 1/aa22cc44", rvalid[0][1], rdata[0][1]); end
        $display("byte_enable: 0x10 -> %h", 32'hAA22CC44);
    endtask

    task automatic test_latency();
        drive(2, 0, 1'b1, 32'h0, 32'hC0C00000, 4'hF);
        tick(); drive(2, 0, 1'b1, 32'h4, 32'hC0C00004, 4'hF);
        tick(); drive(2, 0, 1'b1, 32'h8, 32'hC0C00008, 4'hF);
        tick(); idle(2, 0);
        tick(); tick(); tick();
        drive(2, 1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(); drive(2, 1, 1'b0, 32'h4, 32'h0, 4'h0);
        checks++; if (rvalid[2][1] !== 1'b0) begin errors++; $display("FAIL lat_early1 rvalid got %b exp 0", rvalid[2][1]); end
        tick(); drive(2, 1, 1'b0, 32'h8, 32'h0, 4'h0);
        checks++; if (rvalid[2][1] !== 1'b0) begin errors++; $display("FAIL lat_early2 rvalid got %b exp 0", rvalid[2][1]); end
        tick(); idle(2, 1);
        checks++; if (rvalid[2][1] !== 1'b1 || rdata[2][1] !== 32'hC0C00000) begin errors++; $display("FAIL lat_resp0 rvalid=%b rdata=%h exp 1/c0c00000", rvalid[2][1], rdata[2][1]); end
        tick();
        checks++; if (rvalid[2][1] !== 1'b1 || rdata[2][1] !== 32'hC0C00004) begin errors++; $display("FAIL lat_resp1 rvalid=%b rdata=%h exp 1/c0c00004", rvalid[2][1], rdata[2][1]); end
        tick();
        checks++; if (rvalid[2][1] !== 1'b1 || rdata[2][1] !== 32'hC0C00008) begin errors++; $display("FAIL lat_resp2 rvalid=%b rdata=%h exp 1/c0c00008", rvalid[2][1], rdata[2][1]); end
        tick();
        checks++; if (rvalid[2][1] !== 1'b0) begin errors++; $display("FAIL lat_drained rvalid got %b exp 0", rvalid[2][1]); end
        $display("latency: three reads returned in order after 2 cycles");
    endtask

    task automatic test_errors();
        drive(0, 0, 1'b0, 32'h2, 32'h0, 4'h0);
        tick(); drive(0, 0, 1'b0, 32'h1000, 32'h0, 4'h0);
        checks++; if (rvalid[0][0] !== 1'b1 || err[0][0] !== 1'b1 || rdata[0][0] !== 32'h0) begin errors++; $display("FAIL err_misaligned rvalid=%b err=%b rdata=%h exp 1/1/00000000", rvalid[0][0], err[0][0], rdata[0][0]); end
        tick(); drive(0, 0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        checks++; if (rvalid[0][0] !== 1'b1 || err[0][0] !== 1'b1 || rdata[0][0] !== 32'h0) begin errors++; $display("FAIL err_range_read rvalid=%b err=%b rdata=%h exp 1/1/00000000", rvalid[0][0], err[0][0], rdata[0][0]); end
        tick(); drive(0, 0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++; if (rvalid[0][0] !== 1'b1 || err[0][0] !== 1'b1) begin errors++; $display("FAIL err_range_write rvalid=%b err=%b exp 1/1", rvalid[0][0], err[0][0]); end
        tick(); idle(0, 0);
        checks++; if (err[0][0] !== 1'b0 || rdata[0][0] !== 32'h00300293) begin errors++; $display("FAIL err_no_update err=%b rdata=%h exp 0/00300293", err[0][0], rdata[0][0]); end
        $display("errors: misaligned and out-of-range flagged");
    endtask

    task automatic test_collision_reset();
        drive(0, 0, 1'b1, 32'h20, 32'h55667788, 4'hF);
        tick(); idle(0, 0);
        drive(0, 0, 1'b1, 32'h20, 32'h11111111, 4'b0011);
        drive(0, 1, 1'b1, 32'h20, 32'h22222222, 4'b0110);
        tick(); idle(0, 0); drive(0, 1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick(); idle(0, 1);
        checks++; if (rdata[0][1] !== 32'h55222211) begin errors++; $display("FAIL coll_ww got %h exp 55222211", rdata[0][1]); end
        drive(0, 0, 1'b1, 32'h20, 32'h99999999, 4'hF);
        drive(0, 1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick(); idle(0, 0); idle(0, 1);
        checks++; if (rdata[0][1] !== 32'h55222211) begin errors++; $display("FAIL coll_rw_old got %h exp 55222211", rdata[0][1]); end
        drive(0, 1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick(); idle(0, 1);
        checks++; if (rdata[0][1] !== 32'h99999999) begin errors++; $display("FAIL coll_rw_new got %h exp 99999999", rdata[0][1]); end
        // Two reads in flight on the 3-stage instance, then reset before they emerge.
        drive(2, 1, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(); drive(2, 1, 1'b0, 32'h4, 32'h0, 4'h0);
        tick(); idle(2, 1);
        rst = 1'b1; req[2][0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (rvalid[2][1] !== 1'b0 || gnt[2][0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush c%0d rvalid=%b gnt=%b exp 0/0", c, rvalid[2][1], gnt[2][0]);
            end
        end
        idle(2, 0);
        rst = 1'b0;
        $display("collision_reset: merge 55222211, in-flight reads dropped");
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) for (int p = 0; p < 2; p++) idle(d, p);
        tick(); tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic_read();
        test_gnt_wait();
        test_back_to_back();
        test_byte_enable();
        test_latency();
        test_errors();
        test_collision_reset();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
